// File: rtl/race_sequencer_pkg.sv
// Shared definitions for the two-lane drag race controller: state encoding,
// winner codes, start-tree light patterns and default race parameters.
package race_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COUNTDOWN = 2'd1,
    ST_RACE      = 2'd2,
    ST_FINISH    = 2'd3
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  localparam logic [2:0] LIGHTS_OFF   = 3'b000;
  localparam logic [2:0] LIGHTS_STEP0 = 3'b001;
  localparam logic [2:0] LIGHTS_STEP1 = 3'b011;
  localparam logic [2:0] LIGHTS_STEP2 = 3'b111;

  // Countdown has three light steps, numbered 0..2.
  localparam logic [1:0] LAST_STEP = 2'd2;

  localparam logic [31:0] TRACK_LEN_DEF  = 32'd5000;
  localparam int          COUNT_STEP_DEF = 10;
  localparam logic [15:0] MAX_TIME_DEF   = 16'd1200;

  function automatic logic [2:0] light_pattern(input logic [1:0] step);
    case (step)
      2'd0:    light_pattern = LIGHTS_STEP0;
      2'd1:    light_pattern = LIGHTS_STEP1;
      default: light_pattern = LIGHTS_STEP2;
    endcase
  endfunction

endpackage

// File: rtl/race_sequencer_lane_judge.sv
// Per-lane judge: sticky false-start flag (armed during countdown), finish
// detection against the track length, sticky finished flag and time latch.
module race_sequencer_lane_judge
  import race_sequencer_pkg::*;
#(
  parameter logic [31:0] TRACK_LEN = TRACK_LEN_DEF
) (
  input  logic        clk10Hz,
  input  logic        rst,
  input  logic        clear,
  input  logic        cd_active,
  input  logic        race_active,
  input  logic        launch,
  input  logic [31:0] position,
  input  logic [15:0] race_time,
  output logic        finish_hit,
  output logic        false_start_next,
  output logic        finished,
  output logic        false_start,
  output logic [15:0] lane_time
);

  logic        fs_q, fs_d;
  logic        fin_q, fin_d;
  logic [15:0] time_q, time_d;

  // Next-state of the lane flags; a disqualified or already-finished lane never re-triggers.
  always_comb begin
    finish_hit = race_active & ~fs_q & ~fin_q & (position >= TRACK_LEN);
    fs_d       = fs_q | (cd_active & launch);
    fin_d      = fin_q | finish_hit;
    time_d     = finish_hit ? race_time : time_q;
    if (clear) begin
      fs_d   = 1'b0;
      fin_d  = 1'b0;
      time_d = 16'd0;
    end
  end

  // Lane state registers.
  always_ff @(posedge clk10Hz) begin
    if (rst) begin
      fs_q   <= 1'b0;
      fin_q  <= 1'b0;
      time_q <= 16'd0;
    end else begin
      fs_q   <= fs_d;
      fin_q  <= fin_d;
      time_q <= time_d;
    end
  end

  assign false_start_next = fs_d;
  assign finished         = fin_q;
  assign false_start      = fs_q;
  assign lane_time        = time_q;

endmodule

// File: rtl/race_sequencer.sv
// Two-lane drag race controller: idle -> light countdown -> race -> result.
// Clears the position adders outside the race, gates throttle per lane,
// flags false starts and decides the winner. All outputs are registered.
module race_sequencer
  import race_sequencer_pkg::*;
#(
  parameter logic [31:0] TRACK_LEN  = TRACK_LEN_DEF,
  parameter int          COUNT_STEP = COUNT_STEP_DEF,
  parameter logic [15:0] MAX_TIME   = MAX_TIME_DEF
) (
  input  logic        clk10Hz,
  input  logic        rst,
  input  logic        start_btn,
  input  logic        p1_launch,
  input  logic        p2_launch,
  input  logic [31:0] p1_position,
  input  logic [31:0] p2_position,
  output logic        reset_status,
  output logic [2:0]  lights,
  output logic [1:0]  gas_enable,
  output logic [1:0]  false_start,
  output logic [15:0] p1_time,
  output logic [15:0] p2_time,
  output logic [15:0] race_time,
  output logic [1:0]  winner,
  output logic        timeout,
  output logic [1:0]  state
);

  localparam int TW = (COUNT_STEP > 1) ? $clog2(COUNT_STEP) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(COUNT_STEP - 1);

  state_t          state_q, state_d;
  logic            start_prev_q;
  logic            reset_status_q, reset_status_d;
  logic [2:0]      lights_q, lights_d;
  logic [1:0]      gas_q, gas_d;
  logic [15:0]     race_time_q, race_time_d;
  logic [1:0]      winner_q, winner_d;
  logic            timeout_q, timeout_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [1:0]      step_q, step_d;

  logic            start_edge, clear;
  logic [1:0]      hit, fs_next, fin_q, fs_q, fin_next;
  logic [15:0]     p1_time_w, p2_time_w;

  race_sequencer_lane_judge #(.TRACK_LEN(TRACK_LEN)) u_lane_judge_p1 (
    .clk10Hz(clk10Hz), .rst(rst), .clear(clear),
    .cd_active(state_q == ST_COUNTDOWN), .race_active(state_q == ST_RACE),
    .launch(p1_launch), .position(p1_position), .race_time(race_time_q),
    .finish_hit(hit[0]), .false_start_next(fs_next[0]),
    .finished(fin_q[0]), .false_start(fs_q[0]), .lane_time(p1_time_w)
  );

  race_sequencer_lane_judge #(.TRACK_LEN(TRACK_LEN)) u_lane_judge_p2 (
    .clk10Hz(clk10Hz), .rst(rst), .clear(clear),
    .cd_active(state_q == ST_COUNTDOWN), .race_active(state_q == ST_RACE),
    .launch(p2_launch), .position(p2_position), .race_time(race_time_q),
    .finish_hit(hit[1]), .false_start_next(fs_next[1]),
    .finished(fin_q[1]), .false_start(fs_q[1]), .lane_time(p2_time_w)
  );

  // Sequencer next-state and next-output logic; outputs follow the next state so they stay registered.
  always_comb begin
    state_d     = state_q;
    lights_d    = lights_q;
    race_time_d = race_time_q;
    winner_d    = winner_q;
    timeout_d   = timeout_q;
    tick_d      = tick_q;
    step_d      = step_q;
    clear       = 1'b0;
    start_edge  = start_btn & ~start_prev_q;
    fin_next    = fin_q | hit;

    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d     = ST_COUNTDOWN;
          lights_d    = LIGHTS_STEP0;
          clear       = 1'b1;
          race_time_d = 16'd0;
          winner_d    = WIN_NONE;
          timeout_d   = 1'b0;
          tick_d      = '0;
          step_d      = 2'd0;
        end
      end
      ST_COUNTDOWN: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (step_q == LAST_STEP) begin
            lights_d    = LIGHTS_OFF;
            race_time_d = 16'd0;
            // Both lanes disqualified: nothing left to race.
            state_d     = (fs_next == 2'b11) ? ST_FINISH : ST_RACE;
          end else begin
            step_d   = step_q + 2'd1;
            lights_d = light_pattern(step_q + 2'd1);
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      ST_RACE: begin
        if (winner_q == WIN_NONE) begin
          case (hit)
            2'b01:   winner_d = WIN_P1;
            2'b10:   winner_d = WIN_P2;
            2'b11:   winner_d = WIN_TIE;
            default: winner_d = WIN_NONE;
          endcase
        end
        // A finish on the timeout cycle wins over the timeout.
        if (&(fs_q | fin_next)) begin
          state_d = ST_FINISH;
        end else if (race_time_q == MAX_TIME - 16'd1) begin
          state_d   = ST_FINISH;
          timeout_d = 1'b1;
        end else begin
          race_time_d = race_time_q + 16'd1;
        end
      end
      default: begin
        if (start_edge) state_d = ST_IDLE;
      end
    endcase

    reset_status_d = (state_d == ST_IDLE) || (state_d == ST_COUNTDOWN);
    gas_d          = (state_d == ST_RACE) ? (~fs_next & ~fin_next) : 2'b00;
  end

  // State and output registers; the start detector resets to 1 so a held button cannot start a race.
  always_ff @(posedge clk10Hz) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      start_prev_q   <= 1'b1;
      reset_status_q <= 1'b1;
      lights_q       <= LIGHTS_OFF;
      gas_q          <= 2'b00;
      race_time_q    <= 16'd0;
      winner_q       <= WIN_NONE;
      timeout_q      <= 1'b0;
      tick_q         <= '0;
      step_q         <= 2'd0;
    end else begin
      state_q        <= state_d;
      start_prev_q   <= start_btn;
      reset_status_q <= reset_status_d;
      lights_q       <= lights_d;
      gas_q          <= gas_d;
      race_time_q    <= race_time_d;
      winner_q       <= winner_d;
      timeout_q      <= timeout_d;
      tick_q         <= tick_d;
      step_q         <= step_d;
    end
  end

  assign reset_status = reset_status_q;
  assign lights       = lights_q;
  assign gas_enable   = gas_q;
  assign false_start  = fs_q;
  assign p1_time      = p1_time_w;
  assign p2_time      = p2_time_w;
  assign race_time    = race_time_q;
  assign winner       = winner_q;
  assign timeout      = timeout_q;
  assign state        = state_q;

endmodule

// File: tb/tb_race_sequencer.sv
// Directed bench for race_sequencer. The driver walks the race cycle by cycle
// and pushes hand-computed expectations into exp_q; the monitor drains and
// compares them shortly after each falling edge.
module tb_race_sequencer;

  logic        clk10Hz;
  logic        rst;
  logic        start_btn;
  logic        p1_launch;
  logic        p2_launch;
  logic [31:0] p1_position;
  logic [31:0] p2_position;
  logic        reset_status;
  logic [2:0]  lights;
  logic [1:0]  gas_enable;
  logic [1:0]  false_start;
  logic [15:0] p1_time;
  logic [15:0] p2_time;
  logic [15:0] race_time;
  logic [1:0]  winner;
  logic        timeout;
  logic [1:0]  state;

  localparam int S_STATE = 0, S_LIGHTS = 1, S_RST = 2, S_GAS = 3, S_FS = 4;
  localparam int S_P1T = 5, S_P2T = 6, S_RT = 7, S_WIN = 8, S_TO = 9;

  logic [39:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  race_sequencer dut (
    .clk10Hz(clk10Hz), .rst(rst), .start_btn(start_btn),
    .p1_launch(p1_launch), .p2_launch(p2_launch),
    .p1_position(p1_position), .p2_position(p2_position),
    .reset_status(reset_status), .lights(lights), .gas_enable(gas_enable),
    .false_start(false_start), .p1_time(p1_time), .p2_time(p2_time),
    .race_time(race_time), .winner(winner), .timeout(timeout), .state(state)
  );

  // clock / reset
  initial clk10Hz = 1'b0;
  always #5 clk10Hz = ~clk10Hz;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic string sel_name(input int s);
    case (s)
      S_STATE: sel_name = "state";
      S_LIGHTS: sel_name = "lights";
      S_RST:   sel_name = "reset_status";
      S_GAS:   sel_name = "gas_enable";
      S_FS:    sel_name = "false_start";
      S_P1T:   sel_name = "p1_time";
      S_P2T:   sel_name = "p2_time";
      S_RT:    sel_name = "race_time";
      S_WIN:   sel_name = "winner";
      default: sel_name = "timeout";
    endcase
  endfunction

  function automatic logic [31:0] actual(input int s);
    case (s)
      S_STATE: actual = 32'(state);
      S_LIGHTS: actual = 32'(lights);
      S_RST:   actual = 32'(reset_status);
      S_GAS:   actual = 32'(gas_enable);
      S_FS:    actual = 32'(false_start);
      S_P1T:   actual = 32'(p1_time);
      S_P2T:   actual = 32'(p2_time);
      S_RT:    actual = 32'(race_time);
      S_WIN:   actual = 32'(winner);
      default: actual = 32'(timeout);
    endcase
  endfunction

  // scoreboard monitor
  logic [39:0] mon_e;
  logic [31:0] mon_act;
  always @(negedge clk10Hz) begin
    #2;
    while (exp_q.size() > 0) begin
      mon_e   = exp_q.pop_front();
      mon_act = actual(int'(mon_e[39:32]));
      n_checks++;
      if (mon_act === mon_e[31:0]) n_pass++;
      else $display("FAIL %s: actual=%0d expected=%0d", sel_name(int'(mon_e[39:32])), mon_act, mon_e[31:0]);
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge clk10Hz);
  endtask

  task automatic chk(input int sel, input logic [31:0] v);
    exp_q.push_back({8'(sel), v});
  endtask

  task automatic check_reset_values();
    chk(S_STATE, 0); chk(S_LIGHTS, 0); chk(S_RST, 1); chk(S_GAS, 0); chk(S_FS, 0);
    chk(S_P1T, 0); chk(S_P2T, 0); chk(S_RT, 0); chk(S_WIN, 0); chk(S_TO, 0);
  endtask

  // Requires start_btn low on the previous edge; returns at countdown cycle 1.
  task automatic start_countdown();
    start_btn = 1'b1;
    step(1);
    start_btn = 1'b0;
  endtask

  // Countdown cycles 1..30; launch at the given cycle (0 = none). Returns at first post-countdown cycle.
  task automatic countdown(input int l1, input int l2, input logic [1:0] fs_end);
    for (int c = 1; c <= 30; c++) begin
      p1_launch = (c == l1);
      p2_launch = (c == l2);
      if (c == 1) begin
        chk(S_STATE, 1); chk(S_LIGHTS, 3'b001); chk(S_RST, 1);
        chk(S_FS, 0); chk(S_WIN, 0); chk(S_P1T, 0); chk(S_TO, 0);
      end
      if (c == 10) chk(S_LIGHTS, 3'b001);
      if (c == 11) chk(S_LIGHTS, 3'b011);
      if (c == 20) chk(S_LIGHTS, 3'b011);
      if (c == 21) chk(S_LIGHTS, 3'b111);
      if (c == 30) begin
        chk(S_STATE, 1); chk(S_LIGHTS, 3'b111); chk(S_GAS, 0); chk(S_RST, 1); chk(S_FS, 32'(fs_end));
      end
      step(1);
    end
    p1_launch = 1'b0;
    p2_launch = 1'b0;
  endtask

  // Race cycles k0..k1-1 with positions rate*(k+1) during race_time k.
  task automatic race(input int k0, input int k1, input int r1, input int r2);
    for (int k = k0; k < k1; k++) begin
      p1_position = 32'(r1 * (k + 1));
      p2_position = 32'(r2 * (k + 1));
      if (k == 0) begin
        chk(S_STATE, 2); chk(S_LIGHTS, 0); chk(S_RST, 0); chk(S_RT, 0);
      end
      step(1);
    end
  endtask

  // FINISH -> IDLE via a start press, then one idle cycle with the button released.
  task automatic go_idle();
    p1_position = 32'd0;
    p2_position = 32'd0;
    start_btn = 1'b1;
    step(1);
    chk(S_STATE, 0); chk(S_RST, 1); chk(S_GAS, 0);
    start_btn = 1'b0;
    step(1);
  endtask

  initial begin
    rst = 1'b1; start_btn = 1'b0; p1_launch = 1'b0; p2_launch = 1'b0;
    p1_position = 32'd0; p2_position = 32'd0;
    step(3);
    check_reset_values();
    rst = 1'b0;
    step(2);

    // Clean race: p1 +50/tick finishes at 99, p2 +40/tick at 124.
    start_countdown();
    countdown(0, 0, 2'b00);
    chk(S_GAS, 2'b11);
    race(0, 99, 50, 40);
    chk(S_P1T, 0); chk(S_WIN, 0); chk(S_GAS, 2'b11);
    race(99, 100, 50, 40);
    chk(S_STATE, 2); chk(S_P1T, 99); chk(S_WIN, 2'b01); chk(S_GAS, 2'b10); chk(S_RT, 100);
    race(100, 125, 50, 40);
    chk(S_STATE, 3); chk(S_P1T, 99); chk(S_P2T, 124); chk(S_WIN, 2'b01);
    chk(S_RT, 124); chk(S_TO, 0); chk(S_GAS, 0); chk(S_RST, 0);
    go_idle();

    // Lane 2 false start during light step 1; its later crossing is ignored.
    start_countdown();
    countdown(0, 15, 2'b10);
    chk(S_GAS, 2'b01); chk(S_FS, 2'b10);
    race(0, 100, 50, 60);
    chk(S_STATE, 3); chk(S_P1T, 99); chk(S_P2T, 0); chk(S_WIN, 2'b01);
    chk(S_FS, 2'b10); chk(S_RT, 99);
    go_idle();

    // Tie, with a start press mid-race that must be ignored.
    start_countdown();
    countdown(0, 0, 2'b00);
    race(0, 10, 50, 50);
    start_btn = 1'b1;
    race(10, 11, 50, 50);
    start_btn = 1'b0;
    race(11, 99, 50, 50);
    chk(S_STATE, 2); chk(S_WIN, 0);
    race(99, 100, 50, 50);
    chk(S_STATE, 3); chk(S_WIN, 2'b11); chk(S_P1T, 99); chk(S_P2T, 99);
    go_idle();

    // Timeout: nobody reaches the track length.
    start_countdown();
    countdown(0, 0, 2'b00);
    race(0, 1199, 1, 1);
    chk(S_STATE, 2); chk(S_RT, 1199); chk(S_TO, 0);
    race(1199, 1200, 1, 1);
    chk(S_STATE, 3); chk(S_TO, 1); chk(S_WIN, 0); chk(S_RT, 1199); chk(S_GAS, 0);
    go_idle();

    // Both lanes false-start: straight to FINISH after the countdown.
    start_countdown();
    countdown(5, 25, 2'b11);
    chk(S_STATE, 3); chk(S_FS, 2'b11); chk(S_WIN, 0); chk(S_GAS, 0);
    chk(S_RST, 0); chk(S_LIGHTS, 0); chk(S_RT, 0);
    go_idle();

    // Reset mid-race with the start button held across reset.
    start_countdown();
    countdown(0, 0, 2'b00);
    race(0, 40, 50, 40);
    chk(S_RT, 40);
    rst = 1'b1;
    start_btn = 1'b1;
    step(1);
    check_reset_values();
    step(1);
    rst = 1'b0;
    step(3);
    chk(S_STATE, 0); chk(S_RST, 1); chk(S_LIGHTS, 0);
    start_btn = 1'b0;
    step(1);
    chk(S_STATE, 0);

    step(1);
    #5;
    if (exp_q.size() != 0) $display("FAIL scoreboard: %0d expectations not drained", exp_q.size());
    if (n_checks == 0) $display("FAIL scoreboard: no checks executed");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    if (n_pass == n_checks && n_checks > 0 && exp_q.size() == 0) $display("PASS");
    else $display("FAIL");
    $finish;
  end

endmodule
